mem_stage: RTL and testbench
============================

# mem_stage

Load/store unit between `exe_stage` and the data port of the `RAMHelper` DPI memory. It replaces the raw 64-bit data path from execute to memory and back. It accepts one memory request per handshake from execute, converts the byte address into a RAM word index, and shifts and masks store data by access size. It then extracts and sign- or zero-extends load data, and returns a writeback response to the regfile/commit path through a valid/ready handshake.

## Interface
Parameters:
- `PC_START`, default `64'h8000_0000`: base of RAM; word index = (addr − PC_START) >> 3.
- `XLEN`, default 64: data and address width.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: execute presents a request.
- `req_ready` out 1: stage can accept a request.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in XLEN: byte address (exe_data).
- `req_wdata` in XLEN: store source (rs2 value).
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU/LWU).
- `req_rd` in 5: destination register.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out XLEN: extended load data; 0 for stores.
- `resp_rd` out 5: latched `req_rd`.
- `resp_rd_wen` out 1: 1 for a load that completed without fault.
- `resp_misalign` out 1: address not aligned to `req_size`.
- `ram_ridx` out XLEN: RAM read index.
- `ram_rdata` in XLEN: RAM read data, combinational from `ram_ridx`.
- `ram_widx` out XLEN: RAM write index.
- `ram_wdata` out XLEN: lane-shifted store data.
- `ram_wmask` out XLEN: bit mask, 8 bits per enabled byte.
- `ram_wen` out 1: RAM write strobe.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- `req_ready` = (state == IDLE) || (state == RESP && resp_ready).
- **IDLE / accept:** on `req_valid && req_ready`, latch addr, wdata, size, unsigned, rd, and wen.
  - Misaligned request (addr & ((1<<size) − 1) ≠ 0): go to RESP with `resp_misalign` = 1, `resp_rd_wen` = 0. No RAM access, `ram_wen` never asserted.
  - Aligned request: go to ACCESS.
- **ACCESS** (exactly one cycle):
  - `ram_ridx` = `ram_widx` = (latched addr − PC_START) >> 3.
  - Store: `ram_wen` = 1. `ram_wdata` = wdata << (8·addr[2:0]). `ram_wmask` = (size-ones: 8/16/32/64 bits) << (8·addr[2:0]).
  - Load: register `ram_rdata` >> (8·addr[2:0]), truncated to the size and then extended. Dword ignores `req_unsigned`.
  - Always go to RESP.
- **RESP:** `resp_valid` = 1, and all `resp_*` outputs are held stable until `resp_ready`.
  - On `resp_ready` with a new accepted request: next state is IDLE's accept result (ACCESS or RESP).
  - On `resp_ready` with no new request: go to IDLE.
- Outside ACCESS: `ram_wen`, `ram_wdata`, and `ram_wmask` = 0. `ram_ridx` and `ram_widx` hold the last latched index.
- Address arithmetic is modulo 2^XLEN. There is no range check; addresses below PC_START wrap.

## Timing
- Reset values: state IDLE; `resp_valid`, `resp_rdata`, `resp_rd`, `resp_rd_wen`, `resp_misalign`, `ram_*` all 0; `req_ready` = 1 from the first cycle after reset.
- Latency, aligned request: accepted at edge N, ACCESS during cycle N+1, `resp_valid` high in cycle N+2.
- Latency, misaligned request: `resp_valid` high in cycle N+1.
- Throughput: one request per 2 cycles when `resp_ready` is held high.
- Backpressure: the response stays in RESP indefinitely while `resp_ready` = 0; `req_ready` = 0 during that time.
- Reset while in ACCESS: `ram_wen` is forced to 0 in the reset cycle and the transaction is dropped.
- Reset while in RESP: the response is discarded.
- A store has its side effect exactly once, in ACCESS; a stalled RESP never repeats the write.

## Structure
- Shared package (`defines.v`) holds:
  - `SIZE_B/H/W/D` encodings.
  - FSM state encodings.
  - `PC_START`.
- The sub-module `mem_align` is purely combinational:
  - Inputs: addr[2:0], size, unsigned, wdata, rdata.
  - Outputs: shifted wdata, wmask, extended rdata.
  - It is instantiated once.
- `mem_stage` holds the FSM and the request/response registers.

## Test plan
- **Byte store:** SB, addr 0x8000_0003, wdata 0x..AB.
  - ACCESS cycle: widx 0, wdata 0xAB<<24, wmask 0xFF00_0000, `ram_wen` for exactly 1 cycle.
  - RESP: `resp_rd_wen` = 0.
- **Signed halfword load:** LH, addr 0x8000_0006, RAM word 0x8123_xxxx_xxxx_xxxx.
  - `resp_rdata` = 0xFFFF_FFFF_FFFF_8123, `resp_rd_wen` = 1, `resp_valid` at N+2.
- **Unsigned word load:** LWU, addr 0x8000_0004, RAM upper word 0x8000_0001.
  - `resp_rdata` = 0x0000_0000_8000_0001.
- **Misaligned load:** LW, addr 0x8000_0002.
  - `resp_misalign` = 1 at N+1, `ram_wen` never 1, `resp_rd_wen` = 0.
- **Backpressure:** `resp_ready` = 0 for 5 cycles.
  - `resp_*` stable, `req_ready` = 0, single `ram_wen` pulse for the store.
  - Release with `req_valid` high: new request accepted the same cycle.
- **Reset in ACCESS:** assert `reset` during the ACCESS cycle of a store.
  - `ram_wen` = 0, all outputs 0 next cycle, `req_ready` = 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and helpers for the load/store stage
package mem_stage_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [63:0] PC_START_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SIZE_B:  m = 3'b000;
      SIZE_H:  m = 3'b001;
      SIZE_W:  m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane shifting/masking of store data and extension of load data
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            zext,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] wmask,
  output logic [XLEN-1:0] rdata_ext
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] ones;
  logic [XLEN-1:0] rsh;

  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    ones = '0;
    case (size)
      SIZE_B:  ones[7:0]  = '1;
      SIZE_H:  ones[15:0] = '1;
      SIZE_W:  ones[31:0] = '1;
      default: ones       = '1;
    endcase
  end

  assign wdata_lane = wdata << shamt;
  assign wmask      = ones << shamt;
  assign rsh        = rdata >> shamt;

  // Dword loads pass through untouched, so zext only matters below XLEN.
  always_comb begin
    rdata_ext = rsh;
    case (size)
      SIZE_B:  rdata_ext = zext ? {{(XLEN-8){1'b0}}, rsh[7:0]}
                                : {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      SIZE_H:  rdata_ext = zext ? {{(XLEN-16){1'b0}}, rsh[15:0]}
                                : {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      SIZE_W:  rdata_ext = zext ? {{(XLEN-32){1'b0}}, rsh[31:0]}
                                : {{(XLEN-32){rsh[31]}}, rsh[31:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store unit between execute and the RAM data port
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_START = XLEN'(PC_START_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_rd_wen,
  output logic            resp_misalign,
  output logic [XLEN-1:0] ram_ridx,
  input  logic [XLEN-1:0] ram_rdata,
  output logic [XLEN-1:0] ram_widx,
  output logic [XLEN-1:0] ram_wdata,
  output logic [XLEN-1:0] ram_wmask,
  output logic            ram_wen
);

  state_t state, state_next;

  logic [2:0]      lat_addr_lo;
  logic [XLEN-1:0] lat_wdata;
  logic [1:0]      lat_size;
  logic            lat_zext;
  logic            lat_wen;
  logic [XLEN-1:0] idx;

  logic            accept;
  logic            misaligned;
  logic            store_strobe;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_wmask;
  logic [XLEN-1:0] load_ext;

  assign accept     = req_valid && req_ready;
  assign misaligned = |(req_addr[2:0] & align_mask(req_size));

  mem_align #(.XLEN(XLEN)) u_align (
    .addr_lo    (lat_addr_lo),
    .size       (lat_size),
    .zext       (lat_zext),
    .wdata      (lat_wdata),
    .rdata      (ram_rdata),
    .wdata_lane (lane_wdata),
    .wmask      (lane_wmask),
    .rdata_ext  (load_ext)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = misaligned ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          if (accept) state_next = misaligned ? ST_RESP : ST_ACCESS;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset gates the strobe combinationally so a store caught mid-ACCESS never lands.
  always_comb begin
    req_ready    = (state == ST_IDLE) || ((state == ST_RESP) && resp_ready);
    resp_valid   = (state == ST_RESP);
    store_strobe = (state == ST_ACCESS) && lat_wen && !reset;
    ram_wen      = store_strobe;
    ram_wdata    = store_strobe ? lane_wdata : '0;
    ram_wmask    = store_strobe ? lane_wmask : '0;
  end

  assign ram_ridx = idx;
  assign ram_widx = idx;

  // accept and ACCESS never coincide because req_ready is low in ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_addr_lo   <= '0;
      lat_wdata     <= '0;
      lat_size      <= '0;
      lat_zext      <= 1'b0;
      lat_wen       <= 1'b0;
      idx           <= '0;
      resp_rdata    <= '0;
      resp_rd       <= '0;
      resp_rd_wen   <= 1'b0;
      resp_misalign <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr_lo <= req_addr[2:0];
        lat_wdata   <= req_wdata;
        lat_size    <= req_size;
        lat_zext    <= req_unsigned;
        lat_wen     <= req_wen;
        idx         <= (req_addr - PC_START) >> 3;
        resp_rd     <= req_rd;
        resp_rdata  <= '0;
        resp_rd_wen <= 1'b0;
        resp_misalign <= misaligned;
      end
      if (state == ST_ACCESS) begin
        resp_rdata    <= lat_wen ? '0 : load_ext;
        resp_rd_wen   <= !lat_wen;
        resp_misalign <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_rd_wen;
  logic        resp_misalign;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic        ram_wen;

  logic [63:0] ram [0:3];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wen_cnt = 0;
  int          wen_base;

  always #5 clock = ~clock;

  always_comb begin
    case (ram_ridx)
      64'd0:   ram_rdata = ram[0];
      64'd1:   ram_rdata = ram[1];
      64'd2:   ram_rdata = ram[2];
      64'd3:   ram_rdata = ram[3];
      default: ram_rdata = 64'h0;
    endcase
  end

  always @(negedge clock) if (ram_wen) wen_cnt++;

  mem_stage dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_rd_wen(resp_rd_wen), .resp_misalign(resp_misalign),
    .ram_ridx(ram_ridx), .ram_rdata(ram_rdata), .ram_widx(ram_widx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_rd       = rd;
  endtask

  initial begin
    ram[0] = 64'h8123_4567_89AB_CDEF;
    ram[1] = 64'hFEDC_BA98_0000_0000;
    ram[2] = 64'h0;
    ram[3] = 64'h0;
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; req_rd = '0; resp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("reset_resp_rdata", resp_rdata, 64'd0);
    chk("reset_ram_ridx", ram_ridx, 64'd0);
    chk("reset_ram_wen", {63'd0, ram_wen}, 64'd0);

    // SB to 0x8000_0003
    wen_base = wen_cnt;
    drive(1'b1, 64'h8000_0003, 64'hAB, 2'd0, 1'b0, 5'd5);
    tick();
    req_valid = 1'b0;
    chk("sb_ram_wen", {63'd0, ram_wen}, 64'd1);
    chk("sb_widx", ram_widx, 64'd0);
    chk("sb_wdata", ram_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_wmask", ram_wmask, 64'h0000_0000_FF00_0000);
    chk("sb_access_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("sb_access_req_ready", {63'd0, req_ready}, 64'd0);
    tick();
    chk("sb_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("sb_resp_rd_wen", {63'd0, resp_rd_wen}, 64'd0);
    chk("sb_resp_rdata", resp_rdata, 64'd0);
    chk("sb_resp_rd", {59'd0, resp_rd}, 64'd5);
    chk("sb_resp_ram_wen", {63'd0, ram_wen}, 64'd0);
    chk("sb_resp_wmask", ram_wmask, 64'd0);
    tick();
    chk("sb_idle_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("sb_wen_pulses", 64'(wen_cnt - wen_base), 64'd1);

    // LH from 0x8000_0006
    drive(1'b0, 64'h8000_0006, 64'h0, 2'd1, 1'b0, 5'd7);
    tick();
    req_valid = 1'b0;
    chk("lh_access_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("lh_ridx", ram_ridx, 64'd0);
    chk("lh_ram_wen", {63'd0, ram_wen}, 64'd0);
    tick();
    chk("lh_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("lh_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_8123);
    chk("lh_rd_wen", {63'd0, resp_rd_wen}, 64'd1);
    chk("lh_rd", {59'd0, resp_rd}, 64'd7);
    tick();

    // LWU from 0x8000_0004
    ram[0] = 64'h8000_0001_1234_5678;
    drive(1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b1, 5'd8);
    tick();
    req_valid = 1'b0;
    tick();
    chk("lwu_rdata", resp_rdata, 64'h0000_0000_8000_0001);
    chk("lwu_rd_wen", {63'd0, resp_rd_wen}, 64'd1);
    tick();

    // LW (signed) from 0x8000_000C
    drive(1'b0, 64'h8000_000C, 64'h0, 2'd2, 1'b0, 5'd4);
    tick();
    req_valid = 1'b0;
    chk("lw_ridx", ram_ridx, 64'd1);
    tick();
    chk("lw_rdata", resp_rdata, 64'hFFFF_FFFF_FEDC_BA98);
    tick();

    // Misaligned LW at 0x8000_0002
    wen_base = wen_cnt;
    drive(1'b0, 64'h8000_0002, 64'h0, 2'd2, 1'b0, 5'd6);
    tick();
    req_valid = 1'b0;
    chk("mis_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("mis_misalign", {63'd0, resp_misalign}, 64'd1);
    chk("mis_rd_wen", {63'd0, resp_rd_wen}, 64'd0);
    tick();
    chk("mis_idle", {63'd0, resp_valid}, 64'd0);
    chk("mis_wen_pulses", 64'(wen_cnt - wen_base), 64'd0);

    // SD at 0x8000_0010 with 5 cycles of backpressure
    wen_base = wen_cnt;
    resp_ready = 1'b0;
    drive(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 5'd3);
    tick();
    req_valid = 1'b0;
    chk("sd_widx", ram_widx, 64'd2);
    chk("sd_wmask", ram_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sd_wdata", ram_wdata, 64'h0123_4567_89AB_CDEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_resp_rd", {59'd0, resp_rd}, 64'd3);
      chk("bp_rd_wen", {63'd0, resp_rd_wen}, 64'd0);
      chk("bp_ram_wen", {63'd0, ram_wen}, 64'd0);
      tick();
    end
    // release with a waiting LD (unsigned flag must be ignored)
    resp_ready = 1'b1;
    drive(1'b0, 64'h8000_0008, 64'h0, 2'd3, 1'b1, 5'd9);
    #1;
    chk("bp_release_req_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    chk("ld_access_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("ld_ridx", ram_ridx, 64'd1);
    tick();
    chk("ld_rdata", resp_rdata, 64'hFEDC_BA98_0000_0000);
    chk("ld_rd", {59'd0, resp_rd}, 64'd9);
    chk("bp_wen_pulses", 64'(wen_cnt - wen_base), 64'd1);
    tick();

    // Reset during ACCESS of SW at 0x8000_0018
    wen_base = wen_cnt;
    drive(1'b1, 64'h8000_0018, 64'h55, 2'd2, 1'b0, 5'd2);
    tick();
    req_valid = 1'b0;
    chk("rst_access_ridx", ram_ridx, 64'd3);
    reset = 1'b1;
    #1;
    chk("rst_access_ram_wen", {63'd0, ram_wen}, 64'd0);
    tick();
    reset = 1'b0;
    chk("rst_after_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_after_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_after_ridx", ram_ridx, 64'd0);
    chk("rst_after_rdata", resp_rdata, 64'd0);
    chk("rst_after_rd", {59'd0, resp_rd}, 64'd0);
    tick();
    chk("rst_no_resp", {63'd0, resp_valid}, 64'd0);
    chk("rst_wen_pulses", 64'(wen_cnt - wen_base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
